packet_rx: RTL
==============

Name: packet_rx

Overview:
- RMII/MII receive framer. It hunts for preamble and SFD on rx_dv/rxd, assembles bytes LSB-first, and captures the 14-byte Ethernet header onto a parallel bus.
- Payload bytes (including any pad) stream out on an AXI-stream master with the FCS stripped. The FCS is checked against the CRC-32 residue.
- Sits between the PHY receive pins and the downstream packet parser. It is the receive-side counterpart of the packet transmitter.

Parameters:
- MII_WIDTH, 2, dibit/nibble width of rxd; only 2 and 4 are legal.
- MAX_FRAME_BYTES, 1518, maximum bytes counted from the first header byte through the last FCS byte.
- MIN_PREAMBLE, 4, minimum count of 01-pattern symbols that must precede the SFD terminator.

Ports:
- clk  in  1  Receive clock (50 MHz RMII); all logic on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- rx_dv  in  1  Receive data valid (MII-style, held high for the whole frame).
- rxd  in  MII_WIDTH  Receive data; rxd[0] is the earliest bit on the wire.
- m_axis_tdata  out  8  Payload byte.
- m_axis_tvalid  out  1  One-cycle beat strobe; there is no tready and the block cannot be stalled.
- m_axis_tlast  out  1  Marks the final payload byte of the frame.
- m_axis_tuser  out  1  Valid only with tlast; 1 means the frame is bad (FCS, alignment, or oversize).
- header  out  112  Layout: [111:64] dst MAC, [63:16] src MAC, [15:0] ethertype; the first wire byte sits in the MSBs.
- header_valid  out  1  One-cycle pulse when all 14 header bytes have been captured.
- frame_ok  out  1  One-cycle pulse: the frame ended cleanly with a good FCS.
- frame_err  out  1  One-cycle pulse: the frame was aborted or bad.

Behaviour:
- Reset: all outputs are 0, header = 0, state = IDLE, counters and CRC cleared. A reset mid-frame discards the frame with no tlast, and the block waits for rx_dv low before hunting again.
- Byte assembly:
  - A symbol counter wraps every 8/MII_WIDTH cycles while rx_dv = 1.
  - The byte is shifted in LSB-first; for MII_WIDTH = 2, byte = {d3, d2, d1, d0}.
- State IDLE: when rx_dv = 1, go to PREAMBLE.
- State PREAMBLE (MII_WIDTH = 2):
  - rxd = 01 increments the preamble count.
  - rxd = 11 with count ≥ MIN_PREAMBLE goes to HEADER with the byte counter at 0 and CRC = 32'hFFFFFFFF.
  - Any other symbol, or an early 11, goes to DROP.
  - rx_dv low goes to IDLE silently.
- State HEADER:
  - 14 bytes are loaded into header in wire order.
  - header_valid pulses the cycle after the 14th byte completes; header then stays stable until the next header_valid.
  - Then go to DATA.
- State DATA:
  - Bytes enter a 5-entry delay line.
  - When a 6th byte completes, the oldest byte is emitted: tvalid = 1 for one cycle, tlast = 0.
  - Byte k is therefore emitted one cycle after byte k+5 completes.
- End of frame (rx_dv falls while in DATA):
  - Cycle +1: if the delay line holds exactly 5 bytes, the oldest is emitted with tlast = 1. Those 5 bytes are the last payload byte and the 4 FCS bytes.
  - tuser = 1 if the CRC is bad or the symbol counter was not 0 when rx_dv fell (misaligned).
  - frame_ok = ~tuser and frame_err = tuser, both in the same cycle as tlast.
- CRC:
  - Reflected CRC-32, polynomial 0x04C11DB7 (reflected form 0xEDB88320), processed LSB-first.
  - Covers header, payload and FCS symbols.
  - The frame is good if the register equals 32'hDEBB20E3 after the last FCS symbol.
- Runt: rx_dv falls in HEADER, or in DATA with fewer than 5 bytes in the delay line. Result: frame_err pulse, no beats, no tlast.
- Oversize:
  - When the byte count reaches MAX_FRAME_BYTES + 1, the oldest delay-line byte is emitted with tlast = 1 and tuser = 1.
  - frame_err pulses and the block goes to DROP.
  - Because the count includes the FCS, a MAX_FRAME_BYTES-byte frame is legal.
- State DROP: wait for rx_dv = 0, then go to IDLE. No outputs other than the pulses listed above.
- Back-to-back frames: rx_dv re-asserting in the cycle after the end-of-frame cycle is accepted as a new frame. IDLE→PREAMBLE is taken on the first rx_dv = 1 cycle.
- Payload length is not checked against ethertype; pad bytes pass through, and trimming is done downstream.
- Byte and preamble counters saturate; they never wrap.

Test Plan:
- Frame with dst 02:00:00:00:00:01, src 02:00:00:00:00:02, ethertype 0x002E, payload 0x00..0x2D, valid FCS, 7×55 + D5 preamble -> header = 0x020000000001_020000000002_002E; header_valid once; 46 beats 0x00..0x2D; tlast on 0x2D with tuser = 0; frame_ok pulses.
- Same frame with payload byte 5 bit 3 flipped -> 46 beats; tlast with tuser = 1; frame_err pulses; no frame_ok.
- Same frame with rx_dv dropped one dibit after the last FCS byte started -> tlast with tuser = 1; frame_err.
- Header + FCS only (18 bytes) -> header_valid pulses; 0 beats; frame_err. A frame with a 10-byte header abort -> no header_valid; frame_err.
- 1600-byte frame with MAX_FRAME_BYTES = 1518 -> beats stop with tlast and tuser = 1 after 1500 beats; frame_err; a following valid 64-byte frame -> 46 beats and frame_ok.
- Preamble of only 2×01 then 11 -> DROP with no outputs. Assert rst at header byte 7 -> all outputs 0 the next cycle; the following frame is received correctly.

Source files
------------

// File: rtl/packet_rx.sv
// RMII/MII receive framer: preamble/SFD hunt, LSB-first byte assembly, header
// capture and FCS-stripped payload streaming with CRC-32 residue check.
module packet_rx #(
  parameter int MII_WIDTH       = 2,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_PREAMBLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_dv,
  input  logic [MII_WIDTH-1:0] rxd,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [111:0]         header,
  output logic                 header_valid,
  output logic                 frame_ok,
  output logic                 frame_err
);

  localparam int SYMS = 8 / MII_WIDTH;
  localparam int SC_W = $clog2(SYMS);
  localparam int PC_W = $clog2(MIN_PREAMBLE + 1);
  localparam int BC_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [MII_WIDTH-1:0] PRE_SYM = {(MII_WIDTH/2){2'b01}};
  localparam logic [MII_WIDTH-1:0] SFD_SYM = PRE_SYM | {1'b1, {(MII_WIDTH-1){1'b0}}};
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [BC_W-1:0] BC_OVER = BC_W'(MAX_FRAME_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_DATA, S_DROP} state_t;
  state_t r_state, w_state_next;

  logic [SC_W-1:0]        r_sym_cnt;
  logic [PC_W-1:0]        r_pre_cnt;
  logic [BC_W-1:0]        r_byte_cnt;
  logic [7-MII_WIDTH:0]   r_byte_sh;
  logic [31:0]            r_crc;
  logic [39:0]            r_dl;
  logic [2:0]             r_dl_cnt;
  logic [103:0]           r_hdr_sh;
  logic                   r_seen_idle;

  logic [7:0]      w_byte;
  logic [31:0]     w_crc_next;
  logic [BC_W-1:0] w_byte_cnt_next;
  logic            w_in_frame, w_byte_done, w_sfd;
  logic            w_emit, w_last, w_user, w_hv, w_ok, w_err;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [MII_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < MII_WIDTH; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign w_byte          = {rxd, r_byte_sh};
  assign w_crc_next      = crc_step(r_crc, rxd);
  assign w_in_frame      = (r_state == S_HEADER) || (r_state == S_DATA);
  assign w_byte_done     = rx_dv && w_in_frame && (r_sym_cnt == SC_W'(SYMS - 1));
  assign w_byte_cnt_next = (r_byte_cnt == BC_OVER) ? r_byte_cnt : r_byte_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_sfd  = 1'b0;
    w_emit = 1'b0;
    w_last = 1'b0;
    w_user = 1'b0;
    w_hv   = 1'b0;
    w_ok   = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      // After reset, a frame already in progress is ignored until rx_dv drops.
      S_IDLE: if (rx_dv && r_seen_idle) w_state_next = S_PREAMBLE;
      S_PREAMBLE: begin
        if (!rx_dv) w_state_next = S_IDLE;
        else if (rxd == SFD_SYM && r_pre_cnt >= PC_W'(MIN_PREAMBLE)) begin
          w_state_next = S_HEADER;
          w_sfd        = 1'b1;
        end else if (rxd != PRE_SYM) w_state_next = S_DROP;
      end
      S_HEADER: begin
        if (!rx_dv) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_byte_done && r_byte_cnt == BC_W'(13)) begin
          w_hv         = 1'b1;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!rx_dv) begin
          w_state_next = S_IDLE;
          if (r_dl_cnt == 3'd5) begin
            w_emit = 1'b1;
            w_last = 1'b1;
            w_user = (r_crc != CRC_RESIDUE) || (r_sym_cnt != '0);
            w_ok   = !w_user;
            w_err  = w_user;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_byte_done) begin
          if (w_byte_cnt_next == BC_OVER) begin
            w_emit       = 1'b1;
            w_last       = 1'b1;
            w_user       = 1'b1;
            w_err        = 1'b1;
            w_state_next = S_DROP;
          end else if (r_dl_cnt == 3'd5) begin
            w_emit = 1'b1;
          end
        end
      end
      S_DROP:  if (!rx_dv) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_cnt     <= '0;
      r_pre_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_byte_sh     <= '0;
      r_crc         <= '0;
      r_dl          <= '0;
      r_dl_cnt      <= '0;
      r_hdr_sh      <= '0;
      r_seen_idle   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      header        <= '0;
      header_valid  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (!rx_dv) r_seen_idle <= 1'b1;

      if (w_sfd)      r_sym_cnt <= '0;
      else if (rx_dv) r_sym_cnt <= r_sym_cnt + 1'b1;

      if (rx_dv) r_byte_sh <= w_byte[7:MII_WIDTH];

      // The first symbol after rx_dv rises counts towards the preamble.
      if (r_state == S_IDLE)
        r_pre_cnt <= (rx_dv && rxd == PRE_SYM) ? PC_W'(1) : '0;
      else if (r_state == S_PREAMBLE && rxd == PRE_SYM && r_pre_cnt != PC_W'(MIN_PREAMBLE))
        r_pre_cnt <= r_pre_cnt + 1'b1;

      if (w_sfd)                    r_crc <= 32'hFFFFFFFF;
      else if (rx_dv && w_in_frame) r_crc <= w_crc_next;

      if (w_sfd)            r_byte_cnt <= '0;
      else if (w_byte_done) r_byte_cnt <= w_byte_cnt_next;

      if (w_byte_done && r_state == S_HEADER) r_hdr_sh <= {r_hdr_sh[95:0], w_byte};
      if (w_hv) header <= {r_hdr_sh, w_byte};

      if (w_sfd) r_dl_cnt <= '0;
      else if (w_byte_done && r_state == S_DATA) begin
        r_dl <= {w_byte, r_dl[39:8]};
        if (r_dl_cnt != 3'd5) r_dl_cnt <= r_dl_cnt + 1'b1;
      end

      m_axis_tvalid <= w_emit;
      m_axis_tlast  <= w_last;
      m_axis_tuser  <= w_user;
      if (w_emit) m_axis_tdata <= r_dl[7:0];
      header_valid  <= w_hv;
      frame_ok      <= w_ok;
      frame_err     <= w_err;
    end
  end

endmodule
